// File: rtl/rsa_pkg.sv
// rsa_pkg: sequencer state encoding and uart byte width shared by the uart tx path
package rsa_pkg;
   localparam int BYTE_W = 8;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} seq_state_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side handshake plus uart launch/status signals of uart_tx_fifo
interface uart_tx_fifo_if #(parameter int ABITS = 4);
   import rsa_pkg::*;
   logic [BYTE_W-1:0] in_byte;
   logic [BYTE_W-1:0] tx_byte;
   logic in_valid;
   logic in_last;
   logic in_ready;
   logic transmit;
   logic is_transmitting;
   logic busy;
   logic overflow;
   logic [ABITS:0] count;
   modport master (
      output in_byte, in_valid, in_last, is_transmitting,
      input in_ready, tx_byte, transmit, busy, count, overflow
   );
   modport slave (
      input in_byte, in_valid, in_last, is_transmitting,
      output in_ready, tx_byte, transmit, busy, count, overflow
   );
endinterface

// File: rtl/sync_fifo_byte.sv
// sync_fifo_byte: dual-pointer byte FIFO; pointers wrap naturally, occupancy tracked separately
module sync_fifo_byte
   import rsa_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ABITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [BYTE_W-1:0] rd_data,
   output logic [ABITS:0]    count,
   output logic              full,
   output logic              empty
);
   logic [BYTE_W-1:0] mem [DEPTH];
   logic [ABITS-1:0] wp, rp;
   logic do_wr, do_rd;
   assign full = count == (ABITS+1)'(DEPTH);
   assign empty = count == '0;
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;
   assign rd_data = mem[rp];
   always_ff @(posedge clk)
      if (do_wr) mem[wp] <= wr_data;
   always_ff @(posedge clk)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_wr) wp <= wp + 1'b1;
         if (do_rd) rp <= rp + 1'b1;
         count <= count + (ABITS+1)'(do_wr) - (ABITS+1)'(do_rd);
      end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte buffer + uart launch sequencer; define UART_TX_CHECKSUM_EN to append
// an XOR checksum byte after every byte written with in_last.
module uart_tx_fifo
   import rsa_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ABITS = 4,
   parameter int START_TIMEOUT = 4
) (
   input logic clk,
   input logic rst,
   uart_tx_fifo_if.slave bus
);
   localparam int TW = $clog2(START_TIMEOUT) + 1;
   seq_state_t state, nxt;
   logic [TW-1:0] timer;
   logic [BYTE_W-1:0] wr_data, head, tx_q;
   logic wr_en, rd_en, full, empty, ovf;
   sync_fifo_byte #(.DEPTH(DEPTH), .ABITS(ABITS)) u_fifo (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(head), .count(bus.count), .full(full), .empty(empty)
   );
`ifdef UART_TX_CHECKSUM_EN
   logic [BYTE_W-1:0] acc, csum;
   logic ins, accept;
   // one slot is always kept free so a last byte can be followed by its checksum
   assign bus.in_ready = !ins && !full && bus.count != (ABITS+1)'(DEPTH-1);
   assign accept = bus.in_valid && bus.in_ready;
   assign wr_en = ins || accept;
   assign wr_data = ins ? csum : bus.in_byte;
   always_ff @(posedge clk)
      if (rst) begin
         acc <= '0;
         csum <= '0;
         ins <= 1'b0;
      end else begin
         ins <= accept && bus.in_last;
         if (accept) begin
            acc <= bus.in_last ? '0 : acc ^ bus.in_byte;
            csum <= acc ^ bus.in_byte;
         end
      end
`else
   logic unused_last;
   assign unused_last = bus.in_last;
   assign bus.in_ready = !full;
   assign wr_en = bus.in_valid && bus.in_ready;
   assign wr_data = bus.in_byte;
`endif
   assign rd_en = state == LAUNCH;
   assign bus.transmit = state == LAUNCH;
   assign bus.busy = !empty || state != IDLE;
   assign bus.overflow = ovf;
   assign bus.tx_byte = tx_q;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:       if (!empty && !bus.is_transmitting) nxt = LAUNCH;
         LAUNCH:     nxt = WAIT_START;
         WAIT_START: if (bus.is_transmitting) nxt = WAIT_DONE;
                     else if (timer == TW'(START_TIMEOUT-1)) nxt = IDLE;
         WAIT_DONE:  if (!bus.is_transmitting) nxt = IDLE;
         default:    nxt = IDLE;
      endcase
   end
   // tx_byte is loaded on entry to LAUNCH so it is already valid while transmit is high
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         tx_q <= '0;
         ovf <= 1'b0;
      end else begin
         state <= nxt;
         timer <= state == WAIT_START ? timer + 1'b1 : '0;
         if (state == IDLE && nxt == LAUNCH) tx_q <= head;
         if (bus.in_valid && !bus.in_ready) ovf <= 1'b1;
      end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench with a uart model and a byte scoreboard for uart_tx_fifo
module tb_uart_tx_fifo;
   typedef enum {NORMAL, HOLD, NEVER} mode_t;
   typedef struct {
      logic [7:0] d;
      logic v;
      logic acc;
      logic [4:0] cnt;
      logic rdy;
      logic ovf;
   } vec_t;
   localparam int UART_LEN = 10;
`ifdef UART_TX_CHECKSUM_EN
   localparam int CAP = 15;
`else
   localparam int CAP = 16;
`endif
   logic clk = 1'b0;
   logic rst;
   uart_tx_fifo_if #(.ABITS(4)) bus ();
   uart_tx_fifo #(.DEPTH(16), .ABITS(4), .START_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_tot = 0, n_pass = 0;
   int cyc = 0, pulses = 0, busy_cnt = 0, fall_cyc = 0;
   mode_t mode = NORMAL;
   logic [7:0] exp_q[$];
   vec_t tbl[18];
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask
   // uart model: checks every launch against the scoreboard, then stays busy UART_LEN cycles
   always @(negedge clk) begin
      if (bus.transmit) begin
         pulses++;
         chk("launch while line busy", {31'd0, bus.is_transmitting}, 0);
         if (exp_q.size() == 0) chk("unexpected pulse", bus.tx_byte, 32'hdead);
         else chk("tx_byte order", bus.tx_byte, exp_q.pop_front());
         if (mode == NORMAL) busy_cnt = UART_LEN;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) fall_cyc = cyc;
      end
      bus.is_transmitting = mode == HOLD || busy_cnt > 0;
   end
   task automatic drive(input logic [7:0] d, input logic last);
      bus.in_byte = d;
      bus.in_valid = 1'b1;
      bus.in_last = last;
      exp_q.push_back(d);
      @(negedge clk);
   endtask
   task automatic wait_idle(input string nm);
      for (int i = 0; i < 2000 && bus.busy; i++) @(negedge clk);
      chk(nm, {31'd0, bus.busy}, 0);
   endtask
   task automatic wait_tx(output int at);
      at = -1;
      for (int i = 0; i < 50; i++) begin
         if (bus.transmit) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask
   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      int t1, t2, p0;
      for (int i = 0; i <= CAP + 1; i++) begin
         tbl[i].d = 8'h40 + 8'(i);
         tbl[i].v = i <= CAP;
         tbl[i].acc = i < CAP;
         tbl[i].cnt = i < CAP ? 5'(i + 1) : 5'(CAP);
         tbl[i].rdy = i + 1 < CAP;
         tbl[i].ovf = i >= CAP;
      end
      rst = 1'b1;
      bus.in_byte = '0;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset count", {27'd0, bus.count}, 0);
      chk("reset busy", {31'd0, bus.busy}, 0);
      chk("reset in_ready", {31'd0, bus.in_ready}, 1);
      chk("reset overflow", {31'd0, bus.overflow}, 0);
      chk("reset transmit", {31'd0, bus.transmit}, 0);
      chk("reset tx_byte", {24'd0, bus.tx_byte}, 0);
      rst = 1'b0;
      @(negedge clk);
      // single byte latency and busy release
      drive(8'hA5, 1'b0);
      bus.in_valid = 1'b0;
      chk("latency +1 transmit", {31'd0, bus.transmit}, 0);
      @(negedge clk);
      chk("latency +2 transmit", {31'd0, bus.transmit}, 1);
      chk("latency +2 tx_byte", {24'd0, bus.tx_byte}, 32'hA5);
      wait_idle("single byte busy fall");
      chk("busy falls one cycle after line", cyc, fall_cyc + 1);
      // burst held back by a busy line, then drained
      mode = HOLD;
      @(negedge clk);
      p0 = pulses;
      for (int i = 1; i <= 4; i++) begin
         drive(8'(i), 1'b0);
         chk($sformatf("burst count %0d", i), {27'd0, bus.count}, i);
      end
      bus.in_valid = 1'b0;
      mode = NORMAL;
      wait_idle("burst drain");
      chk("burst pulses", pulses - p0, 4);
      chk("burst scoreboard empty", exp_q.size(), 0);
      // fill past capacity with the line held busy
      mode = HOLD;
      @(negedge clk);
      for (int i = 0; i <= CAP + 1; i++) begin
         bus.in_byte = tbl[i].d;
         bus.in_valid = tbl[i].v;
         bus.in_last = 1'b0;
         if (tbl[i].acc) exp_q.push_back(tbl[i].d);
         @(negedge clk);
         chk($sformatf("fill[%0d] count", i), {27'd0, bus.count}, {27'd0, tbl[i].cnt});
         chk($sformatf("fill[%0d] in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].rdy});
         chk($sformatf("fill[%0d] overflow", i), {31'd0, bus.overflow}, {31'd0, tbl[i].ovf});
      end
      bus.in_valid = 1'b0;
      mode = NORMAL;
      wait_idle("fill drain");
      chk("fill scoreboard empty", exp_q.size(), 0);
      chk("overflow sticky", {31'd0, bus.overflow}, 1);
      pulse_rst();
      chk("overflow cleared by rst", {31'd0, bus.overflow}, 0);
      // reset with bytes queued while the line is busy
      for (int i = 0; i < 6; i++) drive(8'h80 + 8'(i), 1'b0);
      bus.in_valid = 1'b0;
      chk("queued before rst", {27'd0, bus.count}, 5);
      exp_q.delete();
      p0 = pulses;
      pulse_rst();
      chk("rst mid count", {27'd0, bus.count}, 0);
      chk("rst mid busy", {31'd0, bus.busy}, 0);
      chk("rst mid transmit", {31'd0, bus.transmit}, 0);
      repeat (30) @(negedge clk);
      chk("no pulses after rst", pulses - p0, 0);
      // line never starts: start timeout abandons each byte
      mode = NEVER;
      @(negedge clk);
      drive(8'h5A, 1'b0);
      drive(8'hC3, 1'b0);
      bus.in_valid = 1'b0;
      wait_tx(t1);
      chk("timeout first launch", {31'd0, t1 >= 0}, 1);
      @(negedge clk);
      wait_tx(t2);
      chk("timeout launch spacing", t2 - t1, 6);
      repeat (4) @(negedge clk);
      chk("timeout busy before idle", {31'd0, bus.busy}, 1);
      @(negedge clk);
      chk("timeout busy after idle", {31'd0, bus.busy}, 0);
      chk("timeout scoreboard empty", exp_q.size(), 0);
      mode = NORMAL;
      @(negedge clk);
`ifdef UART_TX_CHECKSUM_EN
      p0 = pulses;
      drive(8'h12, 1'b0);
      drive(8'h34, 1'b0);
      drive(8'h56, 1'b1);
      exp_q.push_back(8'h70);
      bus.in_valid = 1'b0;
      chk("checksum insertion stalls in_ready", {31'd0, bus.in_ready}, 0);
      @(negedge clk);
      drive(8'hFF, 1'b1);
      exp_q.push_back(8'hFF);
      bus.in_valid = 1'b0;
      wait_idle("checksum drain");
      chk("checksum pulses", pulses - p0, 6);
      chk("checksum scoreboard empty", exp_q.size(), 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
